// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Execute-stage HI/LO unit. Runs iterative shift-add multiply and restoring
//   divide, owns the architectural HI/LO pair, serves mfhi/mflo/dfhi/dflo, and
//   stalls the pipeline on dependent ops while an iteration is in flight.
//
//   Ports:
//     clk, rst_n             clock (rising edge), synchronous active-low reset
//     op_valid, alu_signal   EX-stage instruction valid and 5-bit ALU code
//     is_unsigned            1 = mulu/divu, 0 = signed
//     rs_val, rt_val         operands (rs also sources dfhi/dflo)
//     busy, stall            op in flight; freeze IF/ID/EX this cycle
//     done, div_by_zero      one-cycle completion pulse; divisor-was-zero flag
//     hi, lo, rd_data        architectural HI/LO; mfhi/mflo read data
//
//   Optional feature: MULDIV_EARLY_ZERO_EN -- a mul with a zero operand or a div
//   with a zero divisor skips RUN and completes one cycle after accept.
//
//   state  | meaning
//   IDLE   | waiting; accepts mul/div, serves mf*/df*
//   RUN    | DATA_W iterations, one bit per cycle (cnt counts down to 0)
//   FIX    | sign correction, HI/LO written at end of cycle, done high
module hilo_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [4:0]        alu_signal,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b10001;
    localparam logic [4:0] OP_DFHI = 5'b10010;
    localparam logic [4:0] OP_DFLO = 5'b10011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] acc, work_lo, opnd_b, rs_raw;
    logic              op_div, neg_q, neg_r, div0;
    logic [CNT_W-1:0]  cnt;

    logic is_mul, is_div, is_mfhi, is_mflo, is_dfhi, is_dflo, is_hilo_op;
    logic accept, skip_run;
    logic rs_neg, rt_neg;
    logic [DATA_W-1:0]   rs_mag, rt_mag;
    logic [DATA_W:0]     trial, sum;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    assign is_mul     = (alu_signal == OP_MUL);
    assign is_div     = (alu_signal == OP_DIV);
    assign is_mfhi    = (alu_signal == OP_MFHI);
    assign is_mflo    = (alu_signal == OP_MFLO);
    assign is_dfhi    = (alu_signal == OP_DFHI);
    assign is_dflo    = (alu_signal == OP_DFLO);
    assign is_hilo_op = is_mul | is_div | is_mfhi | is_mflo | is_dfhi | is_dflo;

    assign accept = (state == S_IDLE) & op_valid & (is_mul | is_div);

    assign rs_neg = ~is_unsigned & rs_val[DATA_W-1];
    assign rt_neg = ~is_unsigned & rt_val[DATA_W-1];
    assign rs_mag = rs_neg ? -rs_val : rs_val;
    assign rt_mag = rt_neg ? -rt_val : rt_val;

    // Restoring divide: partial remainder with next dividend bit, minus divisor.
    assign trial = {acc, work_lo[DATA_W-1]} - {1'b0, opnd_b};
    // Shift-add multiply: add multiplicand when the current multiplier bit is set.
    assign sum   = {1'b0, acc} + (work_lo[0] ? {1'b0, opnd_b} : '0);

    assign prod   = {acc, work_lo};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        skip_run = 1'b0;
`ifdef MULDIV_EARLY_ZERO_EN
        skip_run = (is_mul & ((rs_val == '0) | (rt_val == '0))) |
                   (is_div & (rt_val == '0));
`endif
        fix_hi = prod_s[2*DATA_W-1:DATA_W];
        fix_lo = prod_s[DATA_W-1:0];
        if (op_div) begin
            if (div0) begin
                fix_hi = rs_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? -acc : acc;
                fix_lo = neg_q ? -work_lo : work_lo;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = skip_run ? S_FIX : S_RUN;
            S_RUN:   if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            work_lo <= '0;
            opnd_b  <= '0;
            rs_raw  <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        op_div <= is_div;
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                        div0   <= is_div & (rt_val == '0);
                        rs_raw <= rs_val;
                        cnt    <= CNT_LOAD;
                        if (is_div) begin
                            work_lo <= rs_mag;
                            opnd_b  <= rt_mag;
                        end else begin
                            // A skipped zero multiply must still yield a zero product.
                            work_lo <= skip_run ? '0 : rt_mag;
                            opnd_b  <= rs_mag;
                        end
                    end else if (op_valid & is_dfhi) begin
                        hi <= rs_val;
                    end else if (op_valid & is_dflo) begin
                        lo <= rs_val;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (op_div) begin
                        if (!trial[DATA_W]) begin
                            acc     <= trial[DATA_W-1:0];
                            work_lo <= {work_lo[DATA_W-2:0], 1'b1};
                        end else begin
                            acc     <= {acc[DATA_W-2:0], work_lo[DATA_W-1]};
                            work_lo <= {work_lo[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        acc     <= sum[DATA_W:1];
                        work_lo <= {sum[0], work_lo[DATA_W-1:1]};
                    end
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FIX);
    assign div_by_zero = done & div0;
    assign stall       = busy & op_valid & is_hilo_op;
    assign rd_data     = is_mfhi ? hi : (is_mflo ? lo : '0);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b10001;
    localparam logic [4:0] OP_DFHI = 5'b10010;
    localparam logic [4:0] OP_DFLO = 5'b10011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [4:0]  alu_signal;
    logic        is_unsigned;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo, rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .alu_signal(alu_signal),
        .is_unsigned(is_unsigned), .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    typedef struct {
        logic [4:0]  code;
        logic        uns;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input vec_t v);
        int lat = 33;
`ifdef MULDIV_EARLY_ZERO_EN
        if ((v.code == OP_MUL && (v.rs == 0 || v.rt == 0)) || (v.code == OP_DIV && v.rt == 0))
            lat = 1;
`endif
        return lat;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit seen;
        @(negedge clk);
        op_valid = 1'b1; alu_signal = v.code; is_unsigned = v.uns;
        rs_val = v.rs; rt_val = v.rt;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0; alu_signal = OP_ADD;
        cyc = 1; seen = 0;
        while (cyc <= 100) begin
            #1;
            if (done) begin seen = 1; break; end
            @(negedge clk);
            cyc++;
        end
        if (!seen) begin
            check($sformatf("vec%0d done timeout", idx), 64'(cyc), 64'(exp_latency(v)));
        end else begin
            check($sformatf("vec%0d latency", idx), 64'(cyc), 64'(exp_latency(v)));
            check($sformatf("vec%0d div_by_zero", idx), 64'(div_by_zero), 64'(v.edbz));
            check($sformatf("vec%0d busy_at_done", idx), 64'(busy), 64'd1);
            @(negedge clk); #1;
            check($sformatf("vec%0d hi", idx), 64'(hi), 64'(v.ehi));
            check($sformatf("vec%0d lo", idx), 64'(lo), 64'(v.elo));
            check($sformatf("vec%0d busy_after", idx), 64'(busy), 64'd0);
            check($sformatf("vec%0d done_after", idx), 64'(done), 64'd0);
        end
    endtask

    initial begin
        int bad;
        int dcount;

        vecs[0]  = '{OP_MUL, 1'b0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIV, 1'b1, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{OP_MUL, 1'b0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0};
        vecs[6]  = '{OP_DIV, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[7]  = '{OP_DIV, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{OP_MUL, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[10] = '{OP_DIV, 1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{OP_MUL, 1'b1, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0};

        rst_n = 1'b0; op_valid = 1'b0; alu_signal = OP_ADD; is_unsigned = 1'b0;
        rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // dflo / dfhi writes and mfhi / mflo reads while idle
        @(negedge clk);
        op_valid = 1'b1; alu_signal = OP_DFLO; rs_val = 32'h1234;
        @(negedge clk); #1;
        check("dflo lo", 64'(lo), 64'h1234);
        check("dflo hi untouched", 64'(hi), 64'h0);
        alu_signal = OP_DFHI; rs_val = 32'hCAFE0001;
        @(negedge clk);
        alu_signal = OP_MFHI; #1;
        check("mfhi rd_data", 64'(rd_data), 64'hCAFE0001);
        check("mfhi stall idle", 64'(stall), 64'd0);
        alu_signal = OP_MFLO; #1;
        check("mflo rd_data", 64'(rd_data), 64'h1234);
        alu_signal = OP_ADD; #1;
        check("add rd_data", 64'(rd_data), 64'h0);
        @(negedge clk); #1;
        check("add no write hi", 64'(hi), 64'hCAFE0001);
        op_valid = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Dependent ops stall through FIX; independent op passes; mfhi sees new HI after.
        @(negedge clk);
        op_valid = 1'b1; alu_signal = OP_DIV; is_unsigned = 1'b1;
        rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            op_valid = 1'b1;
            alu_signal = (c == 5) ? OP_ADD : ((c == 10) ? OP_DFHI : OP_MFHI);
            rs_val = 32'hDEAD0000;
            #1;
            if (stall !== ((c == 5) ? 1'b0 : 1'b1)) bad++;
            if (c == 5) check("add while busy stall", 64'(stall), 64'd0);
            if (c == 33) check("stall test done@33", 64'(done), 64'd1);
        end
        check("stall cycles wrong", 64'(bad), 64'd0);
        @(negedge clk);
        alu_signal = OP_MFHI; #1;
        check("mfhi after fix stall", 64'(stall), 64'd0);
        check("mfhi after fix rd_data", 64'(rd_data), 64'd2);
        alu_signal = OP_MFLO; #1;
        check("mflo after fix rd_data", 64'(rd_data), 64'd14);
        op_valid = 1'b0; alu_signal = OP_ADD;

        // Reset during RUN abandons the op.
        @(negedge clk);
        op_valid = 1'b1; alu_signal = OP_MUL; is_unsigned = 1'b0;
        rs_val = 32'd5; rt_val = 32'd9;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            op_valid = 1'b0; alu_signal = OP_ADD;
        end
        #1;
        check("busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (done) dcount++;
        end
        check("midreset done pulses", 64'(dcount), 64'd0);
        check("midreset lo stays", 64'(lo), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
